instr_fetch_queue: RTL and testbench

Parametrised instruction-fetch stage: owns the fetch PC, issues word addresses to a synchronous instruction memory, and buffers returned instructions with their PCs in a small queue. Decode consumes the queue through a valid/ready handshake. Branch and jump redirects flush all wrong-path state, and a stall input freezes PC advance. It sits between the instruction ROM and the decode stage of the pipelined MIPS core.

---
 rtl/instr_fetch_queue.sv | 100 ++++++++++
 tb/tb_instr_fetch_queue.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - fetch PC, single-latency memory issue and instruction queue toward decode
module instr_fetch_queue #(
  parameter int PC_W = 10,
  parameter int INSTR_W = 32,
  parameter int DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               branch_valid,
  input  logic [PC_W-1:0]    branch_pc,
  input  logic               jump_valid,
  input  logic [PC_W-1:0]    jump_pc,
  input  logic               stall,
  output logic               mem_req,
  output logic [PC_W-1:0]    mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0] FULL_OCC = (CNT_W + 1)'(DEPTH);

  logic [PC_W-1:0]    fetchPc;
  logic               inflight;
  logic [PC_W-1:0]    inflightPc;
  logic [PTR_W-1:0]   rdPtr;
  logic [PTR_W-1:0]   wrPtr;
  logic [CNT_W-1:0]   count;
  logic [INSTR_W-1:0] instrQ [DEPTH];
  logic [PC_W-1:0]    pcQ [DEPTH];

  logic               redir;
  logic [PC_W-1:0]    target;
  logic               pop;
  logic               push;
  logic [CNT_W:0]     occupancy;

  assign redir  = branch_valid | jump_valid;
  assign target = branch_valid ? branch_pc : jump_pc;

  assign out_valid = !reset && !redir && (count != '0);
  assign out_instr = instrQ[rdPtr];
  assign out_pc    = pcQ[rdPtr];
  assign pop       = out_valid && out_ready;
  assign push      = inflight && !redir;

  // Credit counts the word already in flight, so a returning word always has a free slot.
  assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight} - {{CNT_W{1'b0}}, pop};
  assign mem_req   = !reset && !redir && !stall && (occupancy < FULL_OCC);
  assign mem_addr  = fetchPc;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetchPc    <= RESET_PC;
      inflight   <= 1'b0;
      inflightPc <= '0;
      rdPtr      <= '0;
      wrPtr      <= '0;
      count      <= '0;
    end else if (redir) begin
      fetchPc    <= target;
      inflight   <= 1'b0;
      inflightPc <= '0;
      rdPtr      <= '0;
      wrPtr      <= '0;
      count      <= '0;
    end else begin
      inflight   <= mem_req;
      inflightPc <= fetchPc;
      if (mem_req) begin
        fetchPc <= fetchPc + PC_W'(1);
      end
      if (push) begin
        wrPtr <= wrPtr + PTR_W'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset; count gates visibility of stale slots.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      instrQ[wrPtr] <= mem_rdata;
      pcQ[wrPtr]    <= inflightPc;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - scoreboard bench for instr_fetch_queue with a word[i] = i ROM
module tb_instr_fetch_queue;

  localparam int PC_W = 10;
  localparam int INSTR_W = 32;
  localparam int DEPTH = 4;
  localparam logic [PC_W-1:0] RESET_PC = '0;

  logic               clk;
  logic               reset;
  logic               branch_valid;
  logic [PC_W-1:0]    branch_pc;
  logic               jump_valid;
  logic [PC_W-1:0]    jump_pc;
  logic               stall;
  logic               mem_req;
  logic [PC_W-1:0]    mem_addr;
  logic [INSTR_W-1:0] mem_rdata;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_pc;

  instr_fetch_queue #(
    .PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .reset(reset),
    .branch_valid(branch_valid), .branch_pc(branch_pc),
    .jump_valid(jump_valid), .jump_pc(jump_pc),
    .stall(stall),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
  );

  int numChecks = 0;
  int numFails = 0;
  int popCnt = 0;
  logic [PC_W-1:0] expQ [$];
  logic [PC_W-1:0] expFetch;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM, one-cycle latency, word[i] = i
  always @(posedge clk) begin
    if (mem_req) mem_rdata <= INSTR_W'(mem_addr);
  end

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    numChecks++;
    if (got !== exp) begin
      numFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic startStream(input logic [PC_W-1:0] pc);
    expQ.delete();
    for (int i = 0; i < 256; i++) expQ.push_back(pc + PC_W'(i));
    expFetch = pc;
  endtask

  // Monitor: every issued address and every accepted instruction against the model
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_req) begin
        checkEq("mem_addr", 32'(mem_addr), 32'(expFetch));
        expFetch = expFetch + PC_W'(1);
      end
      if (out_valid && out_ready) begin
        popCnt++;
        if (expQ.size() == 0) begin
          checkEq("sb_empty", 32'(out_pc), 32'hFFFF_FFFF);
        end else begin
          logic [PC_W-1:0] e;
          e = expQ.pop_front();
          checkEq("out_pc", 32'(out_pc), 32'(e));
          checkEq("out_instr", out_instr, 32'(e));
        end
      end
    end
  end

  initial begin
    int snap;
    logic [PC_W-1:0] heldPc;
    logic [PC_W-1:0] savedFetch;
    reset = 1'b1; branch_valid = 1'b0; jump_valid = 1'b0;
    branch_pc = '0; jump_pc = '0; stall = 1'b0; out_ready = 1'b1;
    expFetch = RESET_PC;
    repeat (3) tick();
    @(negedge clk);
    checkEq("rst_valid", 32'(out_valid), 0);
    checkEq("rst_req", 32'(mem_req), 0);

    // 1: reset release and steady-state streaming
    tick();
    startStream(RESET_PC);
    reset = 1'b0;
    @(negedge clk);
    checkEq("c0_req", 32'(mem_req), 1);
    checkEq("c0_valid", 32'(out_valid), 0);
    tick(); @(negedge clk);
    checkEq("c1_valid", 32'(out_valid), 0);
    tick(); @(negedge clk);
    checkEq("c2_valid", 32'(out_valid), 1);
    checkEq("c2_pc", 32'(out_pc), 32'(RESET_PC));
    tick();
    snap = popCnt;
    repeat (10) tick();
    checkEq("throughput", 32'(popCnt - snap), 10);

    // 2: backpressure fills the queue, then resumes gap-free
    out_ready = 1'b0;
    @(negedge clk);
    heldPc = out_pc;
    repeat (10) tick();
    @(negedge clk);
    checkEq("bp_req", 32'(mem_req), 0);
    checkEq("bp_valid", 32'(out_valid), 1);
    checkEq("bp_hold", 32'(out_pc), 32'(heldPc));
    tick();
    out_ready = 1'b1;
    repeat (8) tick();

    // 3: simultaneous branch and jump, branch wins
    branch_valid = 1'b1; jump_valid = 1'b1;
    branch_pc = 10'h100; jump_pc = 10'h200;
    startStream(10'h100);
    @(negedge clk);
    checkEq("redir_valid", 32'(out_valid), 0);
    checkEq("redir_req", 32'(mem_req), 0);
    tick();
    branch_valid = 1'b0; jump_valid = 1'b0;
    @(negedge clk);
    checkEq("r1_req", 32'(mem_req), 1);
    tick(); @(negedge clk);
    checkEq("r2_valid", 32'(out_valid), 0);
    tick(); @(negedge clk);
    checkEq("r3_valid", 32'(out_valid), 1);
    checkEq("r3_pc", 32'(out_pc), 32'h100);
    repeat (6) tick();

    // 4: stall drains the queue and holds fpc; a jump still redirects
    out_ready = 1'b0;
    repeat (2) tick();
    out_ready = 1'b1; stall = 1'b1;
    savedFetch = expFetch;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkEq("stall_req", 32'(mem_req), 0);
      checkEq("stall_fpc", 32'(mem_addr), 32'(savedFetch));
      tick();
    end
    @(negedge clk);
    checkEq("stall_drained", 32'(out_valid), 0);
    tick();
    jump_valid = 1'b1; jump_pc = 10'h2A0;
    startStream(10'h2A0);
    @(negedge clk);
    checkEq("sj_req", 32'(mem_req), 0);
    tick();
    jump_valid = 1'b0; stall = 1'b0;
    @(negedge clk);
    checkEq("sj_req1", 32'(mem_req), 1);
    checkEq("sj_addr", 32'(mem_addr), 32'h2A0);
    repeat (6) tick();

    // 5: PC wrap at the top of the address space
    jump_valid = 1'b1; jump_pc = 10'h3FE;
    startStream(10'h3FE);
    tick();
    jump_valid = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    checkEq("wrap_pc0", 32'(out_pc), 32'h3FE);
    repeat (2) tick();
    @(negedge clk);
    checkEq("wrap_pc2", 32'(out_pc), 32'h000);
    repeat (4) tick();

    // 6: reset mid-stream with the queue full and a word in flight
    out_ready = 1'b0;
    repeat (8) tick();
    out_ready = 1'b1;
    @(negedge clk);
    checkEq("pre_rst_req", 32'(mem_req), 1);
    tick();
    reset = 1'b1; out_ready = 1'b0;
    startStream(RESET_PC);
    @(negedge clk);
    checkEq("mid_rst_valid", 32'(out_valid), 0);
    checkEq("mid_rst_req", 32'(mem_req), 0);
    tick();
    reset = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checkEq("post_rst_valid", 32'(out_valid), 0);
    checkEq("post_rst_addr", 32'(mem_addr), 32'(RESET_PC));
    tick(); tick();
    @(negedge clk);
    checkEq("post_rst_v2", 32'(out_valid), 1);
    checkEq("post_rst_pc", 32'(out_pc), 32'(RESET_PC));
    repeat (6) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
